md5_block_padder: RTL and testbench
===================================

// Module: md5_block_padder
// PURPOSE
//  Byte-stream front end for the MD5 hash core: accepts an arbitrary-length message one byte per beat,
//  applies MD5 padding (0x80, zero fill, 64-bit little-endian bit length in bytes 56..63) and emits
//  512-bit blocks over a valid/ready handshake, flagging first/last block of each message.
// PARAMETERS
//  COUNT_W  32  width of message byte counter; bit length field = {count,3'b0} zero-extended to 64 bits
// PORTS
//  clk        in   1    clock; all logic on rising edge
//  reset      in   1    synchronous, active-high reset
//  in_valid   in   1    input beat valid
//  in_ready   out  1    padder can accept a beat
//  in_data    in   8    message byte
//  in_last    in   1    beat ends message
//  in_empty   in   1    with in_last: beat carries no byte (zero-length message / terminator only)
//  blk_valid  out  1    blk_data holds a complete block
//  blk_ready  in   1    core accepts block
//  blk_data   out  512  block; message byte k of block at blk_data[511-8k -: 8]
//  blk_first  out  1    block is first of message (core reloads IV)
//  blk_last   out  1    block is final of message (digest valid after core finishes)
// BEHAVIOUR
//  Reset: in_ready=0 for the reset cycle then 1; blk_valid=0, blk_data=0, blk_first=1, blk_last=0;
//   counters/buffer cleared, state FILL. Reset mid-message discards everything, incl. a pending block.
//  States: FILL (accept bytes, in_ready=1), EMIT (present block, in_ready=0), PAD (build extra
//   length-only block, 1 cycle, in_ready=0). Byte accepted on in_valid&&in_ready.
//  FILL: accepted byte written at offset n (0..63), n++, msg count++ (wraps mod 2^COUNT_W).
//   n reaches 64 without last -> EMIT, blk_last=0.
//  Last beat (n = bytes in current block after accept, empty beat adds none):
//   n<=55: byte n=0x80, n+1..55=0, 56..63=length -> EMIT, blk_last=1.
//   56<=n<=63: byte n=0x80, rest 0 -> EMIT blk_last=0; then PAD: all 0, 56..63=length -> EMIT blk_last=1.
//   n==64: EMIT blk_last=0; then PAD: byte0=0x80, rest 0, 56..63=length -> EMIT blk_last=1.
//  Latency: blk_valid asserts cycle after block-completing beat (or after PAD cycle).
//  Handshake: blk_data/first/last stable while blk_valid&&!blk_ready; on transfer buffer cleared,
//   blk_first<=0 (or <=1 if transferred block had blk_last), next state FILL or PAD per pending pad.
//  No overlap: in_ready=0 whenever blk_valid=1, so input and output transfers never coincide.
//  in_empty ignored unless in_last; empty beat with n==0 mid-message still pads correctly.
//  Length: bytes 56..63 = LSB first of 64-bit bit count of whole message.
// CONFIGURATION
//  MD5_PAD_ABORT_EN defined: adds input abort (1b). abort=1 in any state: next cycle FILL, buffer and
//   counters cleared, blk_valid=0 (sole case valid may drop without handshake), blk_first=1; abort
//   outranks simultaneous in_valid/blk_ready. Undefined: no port, no logic.
// STRUCTURE
//  Shared package md5_pkg: MD5_BLOCK_BITS=512, MD5_BLOCK_BYTES=64, MD5_LEN_OFFSET=56,
//   MD5_PAD_BYTE=8'h80, padder state enum.
//  Sub-module md5_pad_len_field: combinational COUNT_W byte count -> 64-bit little-endian bit length bytes.
// TESTING
//  "abc" (61 62 63, last) -> 1 block: 61 62 63 80, zeros, byte56=18, 57..63=0; first=1 last=1.
//  empty beat (in_last=1,in_empty=1) -> 1 block: byte0=80, all else 0; first=1 last=1.
//  56-byte message -> blk1 data+byte56=80, last=0; blk2 zeros, byte56=C0 byte57=01, first=0 last=1.
//  64-byte message -> blk1 data last=0; blk2 byte0=80, byte56=00 byte57=02, last=1.
//  blk_ready low 10 cycles on "abc" -> blk_data stable, in_ready=0; then reset mid 30-byte msg,
//   resend "abc" -> same block as test 1, first=1.
//  MD5_PAD_ABORT_EN: abort while 100-byte msg block 1 pending -> blk_valid=0 next cycle; "abc" ok after.

Source files
------------

// File: rtl/md5_pkg.sv
// Shared MD5 constants and padder state types.
package md5_pkg;
  localparam int MD5_BLOCK_BITS  = 512;
  localparam int MD5_BLOCK_BYTES = 64;
  localparam int MD5_LEN_OFFSET  = 56;
  localparam logic [7:0] MD5_PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {
    PAD_FILL,
    PAD_EMIT,
    PAD_PAD
  } pad_state_t;

  // What the extra length-only block must contain once the current one leaves.
  typedef enum logic [1:0] {
    TAIL_NONE,
    TAIL_LEN,
    TAIL_MARK_LEN
  } pad_tail_t;
endpackage

// File: rtl/md5_pad_len_field.sv
// Byte count -> MD5 length field: 64-bit bit length, least significant byte first
// (first byte lands in bits [63:56], i.e. block byte 56).
module md5_pad_len_field
  import md5_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic [COUNT_W-1:0] count,
  output logic [63:0]        len_bytes
);

  logic [63:0] bit_len;

  always_comb begin
    bit_len = 64'(count) << 3;
    for (int j = 0; j < 8; j++) begin
      len_bytes[63-8*j -: 8] = bit_len[8*j +: 8];
    end
  end

endmodule

// File: rtl/md5_block_padder.sv
// MD5 byte-stream padder: collects message bytes into 512-bit blocks and appends MD5 padding.
// Optional input abort when MD5_PAD_ABORT_EN is defined.
module md5_block_padder
  import md5_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic                      clk,
  input  logic                      reset,
`ifdef MD5_PAD_ABORT_EN
  input  logic                      abort,
`endif
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [7:0]                in_data,
  input  logic                      in_last,
  input  logic                      in_empty,
  output logic                      blk_valid,
  input  logic                      blk_ready,
  output logic [MD5_BLOCK_BITS-1:0] blk_data,
  output logic                      blk_first,
  output logic                      blk_last
);

  pad_state_t                state, state_nxt;
  pad_tail_t                 tail_q, tail_nxt;
  logic [MD5_BLOCK_BITS-1:0] blk_buf, buf_nxt;
  logic [5:0]                n_q, n_nxt;
  logic [COUNT_W-1:0]        count_q, count_nxt, count_inc, len_src;
  logic                      first_q, first_nxt, last_q, last_nxt;
  logic                      byte_add, accept, clear;
  logic [6:0]                n_after;
  logic [63:0]               len_bytes;

`ifdef MD5_PAD_ABORT_EN
  assign clear = reset || abort;
`else
  assign clear = reset;
`endif

  assign in_ready  = (state == PAD_FILL) && !reset;
  assign blk_valid = (state == PAD_EMIT);
  assign blk_data  = blk_buf;
  assign blk_first = first_q;
  assign blk_last  = last_q;

  // An empty terminator beat contributes no byte to the block or the length.
  assign byte_add  = !(in_last && in_empty);
  assign accept    = in_valid && in_ready;
  assign n_after   = {1'b0, n_q} + 7'(byte_add);
  assign count_inc = count_q + COUNT_W'(byte_add);
  assign len_src   = (state == PAD_FILL) ? count_inc : count_q;

  md5_pad_len_field #(.COUNT_W(COUNT_W)) u_len (
    .count     (len_src),
    .len_bytes (len_bytes)
  );

  always_comb begin
    state_nxt = state;
    tail_nxt  = tail_q;
    buf_nxt   = blk_buf;
    n_nxt     = n_q;
    count_nxt = count_q;
    first_nxt = first_q;
    last_nxt  = last_q;
    case (state)
      PAD_FILL: begin
        if (accept) begin
          if (byte_add) buf_nxt[{~n_q, 3'b000} +: 8] = in_data;
          n_nxt     = n_after[5:0];
          count_nxt = count_inc;
          if (in_last) begin
            state_nxt = PAD_EMIT;
            if (n_after < 7'(MD5_LEN_OFFSET)) begin
              buf_nxt[{~n_after[5:0], 3'b000} +: 8] = MD5_PAD_BYTE;
              buf_nxt[63:0] = len_bytes;
              last_nxt      = 1'b1;
              tail_nxt      = TAIL_NONE;
            end else if (n_after < 7'(MD5_BLOCK_BYTES)) begin
              buf_nxt[{~n_after[5:0], 3'b000} +: 8] = MD5_PAD_BYTE;
              last_nxt = 1'b0;
              tail_nxt = TAIL_LEN;
            end else begin
              last_nxt = 1'b0;
              tail_nxt = TAIL_MARK_LEN;
            end
          end else if (n_after == 7'(MD5_BLOCK_BYTES)) begin
            state_nxt = PAD_EMIT;
            last_nxt  = 1'b0;
            tail_nxt  = TAIL_NONE;
          end
        end
      end
      PAD_EMIT: begin
        if (blk_ready) begin
          buf_nxt   = '0;
          n_nxt     = '0;
          first_nxt = last_q;
          last_nxt  = 1'b0;
          if (last_q) count_nxt = '0;
          state_nxt = (tail_q != TAIL_NONE) ? PAD_PAD : PAD_FILL;
        end
      end
      PAD_PAD: begin
        buf_nxt = '0;
        if (tail_q == TAIL_MARK_LEN) buf_nxt[MD5_BLOCK_BITS-1 -: 8] = MD5_PAD_BYTE;
        buf_nxt[63:0] = len_bytes;
        last_nxt  = 1'b1;
        tail_nxt  = TAIL_NONE;
        state_nxt = PAD_EMIT;
      end
      default: state_nxt = PAD_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state   <= PAD_FILL;
      tail_q  <= TAIL_NONE;
      blk_buf <= '0;
      n_q     <= '0;
      count_q <= '0;
      first_q <= 1'b1;
      last_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      tail_q  <= tail_nxt;
      blk_buf <= buf_nxt;
      n_q     <= n_nxt;
      count_q <= count_nxt;
      first_q <= first_nxt;
      last_q  <= last_nxt;
    end
  end

endmodule

// File: tb/tb_md5_block_padder.sv
// Bench for md5_block_padder: message-level MD5 padding model plus directed literal checks.
// Define MD5_PAD_ABORT_EN to also cover the abort input.
module tb_md5_block_padder;

  typedef struct packed {
    logic [511:0] d;
    logic         f;
    logic         l;
  } blk_t;

  logic         clk = 1'b0;
  logic         reset;
`ifdef MD5_PAD_ABORT_EN
  logic         abort;
`endif
  logic         in_valid, in_ready, in_last, in_empty;
  logic [7:0]   in_data;
  logic         blk_valid, blk_ready, blk_first, blk_last;
  logic [511:0] blk_data;

  int   checks = 0;
  int   fails  = 0;
  blk_t exp_q[$];
  blk_t got_q[$];

  always #5 clk = ~clk;

  md5_block_padder #(.COUNT_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef MD5_PAD_ABORT_EN
    .abort     (abort),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_empty  (in_empty),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_first (blk_first),
    .blk_last  (blk_last)
  );

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Standard MD5 padding over the whole message, cut into 64-byte blocks.
  function automatic void model_push(input logic [7:0] m[$]);
    logic [7:0]  p[$];
    logic [63:0] bit_len;
    blk_t        b;
    int          nblk;
    p = m;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bit_len = 64'(m.size()) * 64'd8;
    for (int j = 0; j < 8; j++) p.push_back(bit_len[8*j +: 8]);
    nblk = p.size() / 64;
    for (int bi = 0; bi < nblk; bi++) begin
      b.d = '0;
      for (int k = 0; k < 64; k++) b.d[511-8*k -: 8] = p[64*bi + k];
      b.f = (bi == 0);
      b.l = (bi == nblk - 1);
      exp_q.push_back(b);
    end
  endfunction

  // Every cycle a block is offered, it must match the model's head entry.
  always @(negedge clk) begin
    if (!reset && blk_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_block", 512'(blk_valid), 512'd0);
      end else begin
        chk("blk_data",  blk_data,  exp_q[0].d);
        chk("blk_first", 512'(blk_first), 512'(exp_q[0].f));
        chk("blk_last",  512'(blk_last),  512'(exp_q[0].l));
        chk("in_ready_while_valid", 512'(in_ready), 512'd0);
        if (blk_ready) got_q.push_back(exp_q.pop_front());
      end
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic l, input logic e);
    int   b;
    logic took;
    in_valid = 1'b1; in_data = d; in_last = l; in_empty = e;
    took = 1'b0;
    b = 0;
    while (!took && b < 200) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk); #1;
      b++;
    end
    if (!took) chk("beat_timeout", 512'(took), 512'd1);
    in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0; in_data = 8'h00;
  endtask

  task automatic send_msg(input logic [7:0] m[$], input bit empty_term);
    model_push(m);
    for (int i = 0; i < m.size(); i++)
      send_beat(m[i], (i == m.size() - 1) && !empty_term, 1'b0);
    if (empty_term || m.size() == 0) send_beat(8'h00, 1'b1, 1'b1);
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while ((exp_q.size() != 0 || blk_valid) && b < 2000) begin
      @(posedge clk); #1;
      b++;
    end
    if (b >= 2000) begin
      chk("drain_timeout", 512'(exp_q.size()), 512'd0);
      exp_q.delete();
    end
  endtask

  task automatic chk_count(input string name, input int n);
    chk(name, 512'(got_q.size()), 512'(n));
  endtask

  logic [7:0]   m[$];
  logic [511:0] exp, snap;
  logic [511:0] abc_blk;
  int           b;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; in_empty = 1'b0;
    blk_ready = 1'b1;
`ifdef MD5_PAD_ABORT_EN
    abort = 1'b0;
`endif
    abc_blk = '0;
    abc_blk[511 -: 32] = 32'h6162_6380;
    abc_blk[63:56] = 8'h18;

    @(negedge clk);
    chk("in_ready_during_reset", 512'(in_ready), 512'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_blk_valid", 512'(blk_valid), 512'd0);
    chk("rst_blk_data",  blk_data, 512'd0);
    chk("rst_blk_first", 512'(blk_first), 512'd1);
    chk("rst_blk_last",  512'(blk_last), 512'd0);
    chk("rst_in_ready",  512'(in_ready), 512'd1);
    @(posedge clk); #1;

    // "abc"
    got_q.delete();
    m = '{8'h61, 8'h62, 8'h63};
    send_msg(m, 1'b0);
    wait_idle();
    chk_count("abc_nblk", 1);
    if (got_q.size() == 1) begin
      chk("abc_lit", got_q[0].d, abc_blk);
      chk("abc_fl", 512'({got_q[0].f, got_q[0].l}), 512'(2'b11));
    end

    // Zero-length message
    got_q.delete();
    m.delete();
    send_msg(m, 1'b0);
    wait_idle();
    chk_count("empty_nblk", 1);
    exp = '0; exp[511 -: 8] = 8'h80;
    if (got_q.size() == 1) begin
      chk("empty_lit", got_q[0].d, exp);
      chk("empty_fl", 512'({got_q[0].f, got_q[0].l}), 512'(2'b11));
    end

    // 56 bytes: marker fits, length spills into a second block
    got_q.delete();
    m.delete();
    for (int i = 0; i < 56; i++) m.push_back(8'(i + 1));
    send_msg(m, 1'b0);
    wait_idle();
    chk_count("m56_nblk", 2);
    if (got_q.size() == 2) begin
      chk("m56_b1_tail", got_q[0].d[63:0], 64'h8000_0000_0000_0000);
      chk("m56_b1_fl", 512'({got_q[0].f, got_q[0].l}), 512'(2'b10));
      exp = '0; exp[63:56] = 8'hC0; exp[55:48] = 8'h01;
      chk("m56_b2_lit", got_q[1].d, exp);
      chk("m56_b2_fl", 512'({got_q[1].f, got_q[1].l}), 512'(2'b01));
    end

    // 64 bytes with last on final byte, then the same with a separate empty terminator
    for (int t = 0; t < 2; t++) begin
      got_q.delete();
      m.delete();
      for (int i = 0; i < 64; i++) m.push_back(8'(8'hA0 ^ i));
      send_msg(m, t == 1);
      wait_idle();
      chk_count("m64_nblk", 2);
      exp = '0; exp[511 -: 8] = 8'h80; exp[55:48] = 8'h02;
      if (got_q.size() == 2) begin
        chk("m64_b1_byte63", 512'(got_q[0].d[7:0]), 512'(8'hA0 ^ 8'd63));
        chk("m64_b2_lit", got_q[1].d, exp);
        chk("m64_b2_fl", 512'({got_q[1].f, got_q[1].l}), 512'(2'b01));
      end
    end

    // Multi-block boundaries: 119 (n=55 in block 2) and 120 (n=56 in block 2)
    m.delete();
    for (int i = 0; i < 119; i++) m.push_back(8'($urandom_range(0, 255)));
    send_msg(m, 1'b0);
    wait_idle();
    m.push_back(8'h5A);
    send_msg(m, 1'b0);
    wait_idle();

    // Output stall on "abc"
    blk_ready = 1'b0;
    got_q.delete();
    m = '{8'h61, 8'h62, 8'h63};
    send_msg(m, 1'b0);
    b = 0;
    while (!blk_valid && b < 50) begin @(posedge clk); #1; b++; end
    chk("stall_valid", 512'(blk_valid), 512'd1);
    snap = blk_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_stable", blk_data, snap);
      chk("stall_in_ready", 512'(in_ready), 512'd0);
    end
    @(posedge clk); #1;
    blk_ready = 1'b1;
    wait_idle();
    chk_count("stall_nblk", 1);

    // Reset in the middle of a 30-byte message, then "abc" again
    for (int i = 0; i < 30; i++) send_beat(8'(i), 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 512'(in_ready), 512'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    got_q.delete();
    m = '{8'h61, 8'h62, 8'h63};
    send_msg(m, 1'b0);
    wait_idle();
    chk_count("midrst_nblk", 1);
    if (got_q.size() == 1) begin
      chk("midrst_abc_lit", got_q[0].d, abc_blk);
      chk("midrst_abc_first", 512'(got_q[0].f), 512'd1);
    end

`ifdef MD5_PAD_ABORT_EN
    // Abort while block 1 of a 100-byte message is waiting for the core
    blk_ready = 1'b0;
    m.delete();
    for (int i = 0; i < 100; i++) m.push_back(8'(i * 3));
    exp = '0;
    for (int k = 0; k < 64; k++) exp[511-8*k -: 8] = m[k];
    exp_q.push_back('{d: exp, f: 1'b1, l: 1'b0});
    for (int i = 0; i < 64; i++) send_beat(m[i], 1'b0, 1'b0);
    b = 0;
    while (!blk_valid && b < 50) begin @(posedge clk); #1; b++; end
    chk("abort_pending", 512'(blk_valid), 512'd1);
    abort = 1'b1;
    blk_ready = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    exp_q.delete();
    chk("abort_valid_drop", 512'(blk_valid), 512'd0);
    chk("abort_first", 512'(blk_first), 512'd1);
    got_q.delete();
    m = '{8'h61, 8'h62, 8'h63};
    send_msg(m, 1'b0);
    wait_idle();
    chk_count("abort_abc_nblk", 1);
    if (got_q.size() == 1) chk("abort_abc_lit", got_q[0].d, abc_blk);
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
